// File: rtl/seven_seg_scanner_pkg.sv
// Shared segment encodings (active-low {g,f,e,d,c,b,a}) and display geometry for the scanner.
package seven_seg_scanner_pkg;
  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;
endpackage

// File: rtl/seven_seg_scanner_if.sv
// Load/display bundle between the value source (master) and the scanner (slave).
interface seven_seg_scanner_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_mask;
  logic        blank;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        load_ack;

  modport master (output value, load, dp_mask, blank,
                  input  seg_n, dp_n, an_n, load_ack);
  modport slave  (input  value, load, dp_mask, blank,
                  output seg_n, dp_n, an_n, load_ack);
endinterface

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// Combinational nibble to active-low segment lookup; zero latency, no flow control.
module hex_to_seg
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    case (nibble)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed hex display with frame-boundary double buffering; pins lag digit/shown by one cycle.
// Loads are never refused (last load wins); SEVSEG_ZERO_BLANK_EN enables leading-zero suppression.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
)
(
  input  logic               clock,
  input  logic               reset,
  seven_seg_scanner_if.slave bus
);

  logic [CNT_W-1:0]      prescaler;
  logic [1:0]            digit;
  logic [15:0]           shown;
  logic [15:0]           pending;
  logic                  pending_valid;
  logic                  tick;
  logic                  frame_end;
  logic [3:0]            nibble;
  logic [6:0]            seg_lut;
  logic                  suppress;
  logic [NUM_DIGITS-1:0] an_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;
  logic                  ack_q;

  assign tick      = (prescaler == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = tick && (digit == 2'd3);
  assign nibble    = shown[{digit, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg_n  (seg_lut)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      digit     <= 2'd0;
    end else begin
      prescaler <= tick ? '0 : prescaler + CNT_W'(1);
      if (tick) begin
        digit <= digit + 2'd1;
      end
    end
  end

  // Commit uses the pre-edge pending, so a load on the frame boundary waits a full frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shown         <= 16'h0000;
      pending       <= 16'h0000;
      pending_valid <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (frame_end && pending_valid) begin
        shown <= pending;
        ack_q <= 1'b1;
      end
      if (bus.load) begin
        pending       <= bus.value;
        pending_valid <= 1'b1;
      end else if (frame_end) begin
        pending_valid <= 1'b0;
      end
    end
  end

`ifdef SEVSEG_ZERO_BLANK_EN
  always_comb begin
    suppress = 1'b0;
    case (digit)
      2'd1:    suppress = (shown[15:4]  == 12'h000);
      2'd2:    suppress = (shown[15:8]  == 8'h00);
      2'd3:    suppress = (shown[15:12] == 4'h0);
      default: suppress = 1'b0;
    endcase
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    an_next = ~(NUM_DIGITS'(1) << digit);
    dp_next = ~bus.dp_mask[digit];
    if (bus.blank || suppress) begin
      an_next = '1;
    end
    if (suppress) begin
      dp_next = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_next;
      seg_q <= seg_lut;
      dp_q  <= dp_next;
    end
  end

  assign bus.an_n     = an_q;
  assign bus.seg_n    = seg_q;
  assign bus.dp_n     = dp_q;
  assign bus.load_ack = ack_q;

endmodule
